ysyx_22050019_mem_wb_pipe: RTL and testbench
============================================

# ysyx_22050019_mem_wb_pipe

Parametrised MEM→WB pipeline stage that replaces the plain stall-gated MEM/WB register with a two-entry valid/ready skid buffer. It merges the EXU/CSR and LSU write-back sources with defined priority, supports flush, and drives a single-cycle commit pulse to the WBU/regfile. It also maintains a retired-instruction counter and, when configured, carries CSR snapshots and ebreak detection for difftest. It sits between the LSU and the WBU/regfile.

## Interface
Parameters:
- XLEN, 64, datapath and PC width
- NR_CSR, 4, number of CSR snapshot words carried for difftest
- CNT_W, 64, retired-instruction counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-high reset (asserted = 1 resets the block)
- flush_i  in  1  drop all buffered entries
- in_valid_i  in  1  upstream entry valid
- in_ready_o  out  1  stage can accept; registered
- pc_i  in  XLEN  PC of incoming instruction
- inst_i  in  32  instruction word
- reg_we_exu_i  in  1  EXU/CSR result writes the register file
- reg_waddr_exu_i  in  5  EXU destination
- reg_wdata_exu_i  in  XLEN  EXU result
- csr_sel_i  in  1  take reg_wdata_csr_i instead of reg_wdata_exu_i
- reg_wdata_csr_i  in  XLEN  CSR read value
- reg_we_lsu_i  in  1  load result writes the register file
- reg_waddr_lsu_i  in  5  load destination
- reg_wdata_lsu_i  in  XLEN  load data
- csr_snap_i  in  NR_CSR*XLEN  flattened CSR snapshot; word k at bits [k*XLEN +: XLEN]
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  WBU accepts head entry
- pc_o  out  XLEN  head PC
- inst_o  out  32  head instruction
- reg_we_o  out  1  head write enable
- reg_waddr_o  out  5  head destination
- reg_wdata_o  out  XLEN  head write data
- csr_snap_o  out  NR_CSR*XLEN  head CSR snapshot
- commit_o  out  1  combinational out_valid_o & out_ready_i
- retire_cnt_o  out  CNT_W  retired-instruction count
- wb_conflict_o  out  1  sticky: both write sources asserted on an accepted entry
- ebreak_o  out  1  head entry is ebreak (0x00100073) and commits

## Operation
- Accept: in_valid_i & in_ready_o. Transfer out: commit_o.
- Merge at capture: if reg_we_exu_i, we=1, waddr=reg_waddr_exu_i, wdata = csr_sel_i ? csr : exu. Else if reg_we_lsu_i, use the LSU fields. Else we=0, waddr=0, wdata=0.
- If both write enables are set, the EXU source wins and wb_conflict_o is set until reset.
- x0 rule: a captured waddr of 0 forces the stored we to 0; the data is kept.
- Storage: main entry (head, drives outputs) plus a skid entry.
- States:
  - EMPTY: no valid entry.
  - ONE: main valid.
  - TWO: main and skid valid.
- Transitions (without flush):
  - EMPTY + accept → ONE.
  - ONE + accept, no commit → TWO (data into skid).
  - ONE + accept + commit → ONE (main reloaded).
  - ONE + commit, no accept → EMPTY.
  - TWO + commit → ONE (skid moves to main).
  - TWO + no commit → TWO.
- in_ready_o is registered and equals (next state != TWO); it is 1 in EMPTY/ONE and 0 in TWO.
- Outputs when out_valid_o = 0: pc_o, inst_o, reg_we_o, reg_waddr_o, reg_wdata_o, csr_snap_o are all 0.
- retire_cnt_o increments by 1 per commit_o and wraps from 2^CNT_W−1 to 0. Flush does not change it.
- Flush: the next state is EMPTY and both entries are invalidated. A concurrent accept is dropped. A concurrent commit_o still counts, because the WBU has already consumed the entry.

## Timing
- Reset (rst_n = 1 at an edge) sets:
  - state = EMPTY, out_valid_o = 0, in_ready_o = 1.
  - All data outputs = 0, retire_cnt_o = 0, wb_conflict_o = 0, commit_o = 0, ebreak_o = 0.
- Reset has priority over flush and accept; reset mid-operation discards all entries.
- Latency: accepted in cycle N → out_valid_o in cycle N+1.
- Throughput: 1 entry/cycle when out_ready_i is held at 1.
- Back-pressure: out_ready_i low for 2+ cycles fills the skid; in_ready_o drops one cycle after the second accept.
- No combinational path from out_ready_i to in_ready_o.
- The head entry is stable while out_valid_o & !out_ready_i.

## Configuration
- YSYX_22050019_DIFFTEST_EN defined:
  - CSR snapshot is stored per entry and driven on csr_snap_o.
  - ebreak_o = commit_o & (inst_o == 32'h00100073).
- Undefined:
  - No snapshot storage; csr_snap_o = 0 and csr_snap_i is ignored.
  - ebreak_o = 0.
  - All other behaviour is identical.

## Test plan
- Reset, then streaming: hold rst_n = 1 for 2 cycles, then stream 4 entries with out_ready_i = 1 → each appears 1 cycle after accept, commit_o pulses 4 times, retire_cnt_o = 4.
- Merge priority: reg_we_exu_i = 1, waddr 5, csr_sel_i = 1, csr 0xAA; LSU we = 1, waddr 7 → reg_waddr_o = 5, reg_wdata_o = 0xAA, wb_conflict_o = 1 and stays 1.
- Back-pressure: out_ready_i = 0 while accepting A, B → in_ready_o = 0 in the cycle after B's accept. Release out_ready_i → A then B output in order, no loss or duplication.
- Flush collision: in state TWO, assert flush_i with in_valid_i = 1 → next cycle out_valid_o = 0, in_ready_o = 1, and the flushed entries never commit.
- x0 and wrap (CNT_W = 3): LSU write to waddr 0 → reg_we_o = 0. 9 commits → retire_cnt_o = 1.
- Difftest (YSYX_22050019_DIFFTEST_EN): commit inst 0x00100073 with csr_snap_i word 1 = 0x8000_0004 → ebreak_o = 1 for 1 cycle, csr_snap_o word 1 = 0x8000_0004. Without the macro → ebreak_o = 0, csr_snap_o = 0.

Source files
------------

// File: rtl/ysyx_22050019_mem_wb_pipe.sv
// MEM->WB stage: two-entry valid/ready skid buffer with write-back source merge, flush and retire counter.
// Optional difftest support (CSR snapshots, ebreak detection) is enabled by defining YSYX_22050019_DIFFTEST_EN.
module ysyx_22050019_mem_wb_pipe #(
  parameter int XLEN   = 64,
  parameter int NR_CSR = 4,
  parameter int CNT_W  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [31:0]            inst_i,
  input  logic                   reg_we_exu_i,
  input  logic [4:0]             reg_waddr_exu_i,
  input  logic [XLEN-1:0]        reg_wdata_exu_i,
  input  logic                   csr_sel_i,
  input  logic [XLEN-1:0]        reg_wdata_csr_i,
  input  logic                   reg_we_lsu_i,
  input  logic [4:0]             reg_waddr_lsu_i,
  input  logic [XLEN-1:0]        reg_wdata_lsu_i,
  input  logic [NR_CSR*XLEN-1:0] csr_snap_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [XLEN-1:0]        pc_o,
  output logic [31:0]            inst_o,
  output logic                   reg_we_o,
  output logic [4:0]             reg_waddr_o,
  output logic [XLEN-1:0]        reg_wdata_o,
  output logic [NR_CSR*XLEN-1:0] csr_snap_o,
  output logic                   commit_o,
  output logic [CNT_W-1:0]       retire_cnt_o,
  output logic                   wb_conflict_o,
  output logic                   ebreak_o
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state, state_next;
  logic   in_ready_q;
  logic   accept, commit;
  logic   load_main_in, load_skid_in, load_main_skid;

  logic            cap_we;
  logic [4:0]      cap_waddr;
  logic [XLEN-1:0] cap_wdata;

  logic [XLEN-1:0] main_pc, skid_pc;
  logic [31:0]     main_inst, skid_inst;
  logic            main_we, skid_we;
  logic [4:0]      main_waddr, skid_waddr;
  logic [XLEN-1:0] main_wdata, skid_wdata;
  logic [CNT_W-1:0] retire_cnt;
  logic            conflict_q;

  assign accept      = in_valid_i & in_ready_q;
  assign out_valid_o = (state != EMPTY);
  assign commit      = out_valid_o & out_ready_i;
  assign commit_o    = commit;
  assign in_ready_o  = in_ready_q;

  // EXU/CSR result has priority over the load result; writes to x0 are suppressed.
  always_comb begin
    cap_we    = 1'b0;
    cap_waddr = 5'd0;
    cap_wdata = '0;
    if (reg_we_exu_i) begin
      cap_we    = 1'b1;
      cap_waddr = reg_waddr_exu_i;
      cap_wdata = csr_sel_i ? reg_wdata_csr_i : reg_wdata_exu_i;
    end else if (reg_we_lsu_i) begin
      cap_we    = 1'b1;
      cap_waddr = reg_waddr_lsu_i;
      cap_wdata = reg_wdata_lsu_i;
    end
    if (cap_waddr == 5'd0) cap_we = 1'b0;
  end

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_skid_in   = 1'b0;
    load_main_skid = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_next   = ONE;
        load_main_in = 1'b1;
      end
      ONE: begin
        if (accept && commit) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_next   = TWO;
          load_skid_in = 1'b1;
        end else if (commit) begin
          state_next = EMPTY;
        end
      end
      TWO: if (commit) begin
        state_next     = ONE;
        load_main_skid = 1'b1;
      end
      default: state_next = EMPTY;
    endcase
    if (flush_i) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_skid_in   = 1'b0;
      load_main_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      retire_cnt <= '0;
      conflict_q <= 1'b0;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != TWO);
      if (commit) retire_cnt <= retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (accept && !flush_i && reg_we_exu_i && reg_we_lsu_i) conflict_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      main_pc <= '0; main_inst <= '0; main_we <= 1'b0; main_waddr <= '0; main_wdata <= '0;
      skid_pc <= '0; skid_inst <= '0; skid_we <= 1'b0; skid_waddr <= '0; skid_wdata <= '0;
    end else begin
      if (load_main_in) begin
        main_pc <= pc_i; main_inst <= inst_i; main_we <= cap_we;
        main_waddr <= cap_waddr; main_wdata <= cap_wdata;
      end else if (load_main_skid) begin
        main_pc <= skid_pc; main_inst <= skid_inst; main_we <= skid_we;
        main_waddr <= skid_waddr; main_wdata <= skid_wdata;
      end
      if (load_skid_in) begin
        skid_pc <= pc_i; skid_inst <= inst_i; skid_we <= cap_we;
        skid_waddr <= cap_waddr; skid_wdata <= cap_wdata;
      end
    end
  end

  assign pc_o          = out_valid_o ? main_pc    : '0;
  assign inst_o        = out_valid_o ? main_inst  : '0;
  assign reg_we_o      = out_valid_o & main_we;
  assign reg_waddr_o   = out_valid_o ? main_waddr : '0;
  assign reg_wdata_o   = out_valid_o ? main_wdata : '0;
  assign retire_cnt_o  = retire_cnt;
  assign wb_conflict_o = conflict_q;

`ifdef YSYX_22050019_DIFFTEST_EN
  logic [NR_CSR*XLEN-1:0] main_snap, skid_snap;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      main_snap <= '0;
      skid_snap <= '0;
    end else begin
      if (load_main_in)        main_snap <= csr_snap_i;
      else if (load_main_skid) main_snap <= skid_snap;
      if (load_skid_in)        skid_snap <= csr_snap_i;
    end
  end

  assign csr_snap_o = out_valid_o ? main_snap : '0;
  assign ebreak_o   = commit & (inst_o == 32'h00100073);
`else
  logic unused_snap;
  assign unused_snap = ^csr_snap_i;
  assign csr_snap_o  = '0;
  assign ebreak_o    = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22050019_mem_wb_pipe.sv
// Scoreboard bench for ysyx_22050019_mem_wb_pipe (CNT_W = 3 to exercise counter wrap).
module tb_ysyx_22050019_mem_wb_pipe;
  localparam int XLEN = 64, NR_CSR = 4, CNT_W = 3, SW = NR_CSR * XLEN;

  logic clk = 1'b0;
  logic rst_n = 1'b1, flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [XLEN-1:0] pc_i = '0, reg_wdata_exu_i = '0, reg_wdata_csr_i = '0, reg_wdata_lsu_i = '0;
  logic [31:0] inst_i = '0;
  logic reg_we_exu_i = 1'b0, csr_sel_i = 1'b0, reg_we_lsu_i = 1'b0;
  logic [4:0] reg_waddr_exu_i = '0, reg_waddr_lsu_i = '0;
  logic [SW-1:0] csr_snap_i = '0;
  logic in_ready_o, out_valid_o, reg_we_o, commit_o, wb_conflict_o, ebreak_o;
  logic [XLEN-1:0] pc_o, reg_wdata_o;
  logic [31:0] inst_o;
  logic [4:0] reg_waddr_o;
  logic [SW-1:0] csr_snap_o;
  logic [CNT_W-1:0] retire_cnt_o;

  ysyx_22050019_mem_wb_pipe #(.XLEN(XLEN), .NR_CSR(NR_CSR), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .inst_i(inst_i), .reg_we_exu_i(reg_we_exu_i), .reg_waddr_exu_i(reg_waddr_exu_i),
    .reg_wdata_exu_i(reg_wdata_exu_i), .csr_sel_i(csr_sel_i), .reg_wdata_csr_i(reg_wdata_csr_i),
    .reg_we_lsu_i(reg_we_lsu_i), .reg_waddr_lsu_i(reg_waddr_lsu_i), .reg_wdata_lsu_i(reg_wdata_lsu_i),
    .csr_snap_i(csr_snap_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .pc_o(pc_o),
    .inst_o(inst_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .csr_snap_o(csr_snap_o), .commit_o(commit_o), .retire_cnt_o(retire_cnt_o),
    .wb_conflict_o(wb_conflict_o), .ebreak_o(ebreak_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, in_valid, out_ready, flush;
    logic [XLEN-1:0] pc;
    logic [31:0] inst;
    logic exu_we;
    logic [4:0] exu_addr;
    logic [XLEN-1:0] exu_data;
    logic csr_sel;
    logic [XLEN-1:0] csr_data;
    logic lsu_we;
    logic [4:0] lsu_addr;
    logic [XLEN-1:0] lsu_data;
    logic [SW-1:0] snap;
  } stim_t;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [31:0] inst;
    logic we;
    logic [4:0] waddr;
    logic [XLEN-1:0] wdata;
    logic [SW-1:0] snap;
  } entry_t;

  entry_t sb_q[$];
  logic [CNT_W-1:0] m_cnt = '0;
  logic m_conflict = 1'b0, m_ready = 1'b1;
  int checks = 0, errors = 0;

  task automatic checkOutput(input string tag, input logic [SW-1:0] actual, input logic [SW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic stim_t idle(input logic out_ready);
    stim_t s;
    s = '{default: '0};
    s.out_ready = out_ready;
    return s;
  endfunction

  function automatic stim_t exu_op(input logic [XLEN-1:0] pc, input logic [4:0] a, input logic [XLEN-1:0] d);
    stim_t s;
    s = idle(1'b1);
    s.in_valid = 1'b1; s.pc = pc; s.inst = 32'h00000013 | {pc[11:0], 20'h0};
    s.exu_we = 1'b1; s.exu_addr = a; s.exu_data = d;
    return s;
  endfunction

  function automatic entry_t merge(input stim_t s);
    entry_t e;
    e.pc = s.pc; e.inst = s.inst; e.snap = s.snap;
    e.we = 1'b0; e.waddr = '0; e.wdata = '0;
    if (s.exu_we) begin
      e.we = 1'b1; e.waddr = s.exu_addr; e.wdata = s.csr_sel ? s.csr_data : s.exu_data;
    end else if (s.lsu_we) begin
      e.we = 1'b1; e.waddr = s.lsu_addr; e.wdata = s.lsu_data;
    end
    if (e.waddr == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  // One clock: drive, check head against the scoreboard, then advance the model at the edge.
  task automatic applyStimulus(input stim_t s);
    logic exp_accept, exp_commit, exp_ebreak;
    entry_t head;
    @(negedge clk);
    rst_n = s.rst; flush_i = s.flush; in_valid_i = s.in_valid; out_ready_i = s.out_ready;
    pc_i = s.pc; inst_i = s.inst; reg_we_exu_i = s.exu_we; reg_waddr_exu_i = s.exu_addr;
    reg_wdata_exu_i = s.exu_data; csr_sel_i = s.csr_sel; reg_wdata_csr_i = s.csr_data;
    reg_we_lsu_i = s.lsu_we; reg_waddr_lsu_i = s.lsu_addr; reg_wdata_lsu_i = s.lsu_data;
    csr_snap_i = s.snap;
    #1;
    head = '{default: '0};
    if (sb_q.size() != 0) head = sb_q[0];
    exp_accept = s.in_valid & m_ready;
    exp_commit = (sb_q.size() != 0) & s.out_ready;
    exp_ebreak = 1'b0;
`ifdef YSYX_22050019_DIFFTEST_EN
    exp_ebreak = exp_commit & (head.inst == 32'h00100073);
`else
    head.snap = '0;
`endif
    checkOutput("out_valid", out_valid_o, sb_q.size() != 0);
    checkOutput("in_ready", in_ready_o, m_ready);
    checkOutput("commit", commit_o, exp_commit);
    checkOutput("retire_cnt", retire_cnt_o, m_cnt);
    checkOutput("conflict", wb_conflict_o, m_conflict);
    checkOutput("ebreak", ebreak_o, exp_ebreak);
    checkOutput("pc", pc_o, head.pc);
    checkOutput("inst", inst_o, head.inst);
    checkOutput("we", reg_we_o, head.we);
    checkOutput("waddr", reg_waddr_o, head.waddr);
    checkOutput("wdata", reg_wdata_o, head.wdata);
    checkOutput("snap", csr_snap_o, head.snap);
    @(posedge clk);
    if (s.rst) begin
      sb_q.delete(); m_cnt = '0; m_conflict = 1'b0;
    end else begin
      if (exp_commit) begin
        void'(sb_q.pop_front());
        m_cnt = m_cnt + 1'b1;
      end
      if (s.flush) sb_q.delete();
      else if (exp_accept) begin
        sb_q.push_back(merge(s));
        if (s.exu_we && s.lsu_we) m_conflict = 1'b1;
      end
    end
    m_ready = (sb_q.size() != 2);
  endtask

  initial begin
    stim_t s;
    logic exp_eb;
    logic [XLEN-1:0] exp_w1;
    // reset held for two cycles
    s = idle(1'b1); s.rst = 1'b1;
    applyStimulus(s); applyStimulus(s);

    for (int i = 0; i < 4; i++) applyStimulus(exu_op(64'h8000_0000 + 64'(4 * i), 5'(i + 1), 64'h1000 + 64'(i)));
    applyStimulus(idle(1'b1));
    #2 checkOutput("stream_retire4", retire_cnt_o, 4);

    // both sources write: EXU/CSR wins and the conflict flag sticks
    s = exu_op(64'h8000_0100, 5'd5, 64'h55);
    s.csr_sel = 1'b1; s.csr_data = 64'hAA; s.lsu_we = 1'b1; s.lsu_addr = 5'd7; s.lsu_data = 64'h77;
    applyStimulus(s);
    #2;
    checkOutput("merge_waddr", reg_waddr_o, 5);
    checkOutput("merge_wdata", reg_wdata_o, 64'hAA);
    checkOutput("merge_conflict", wb_conflict_o, 1);
    applyStimulus(idle(1'b1)); applyStimulus(idle(1'b1));
    #2 checkOutput("conflict_sticky", wb_conflict_o, 1);

    // back-pressure fills the skid entry
    s = exu_op(64'h8000_0200, 5'd10, 64'hA0A0); s.out_ready = 1'b0; applyStimulus(s);
    s = exu_op(64'h8000_0204, 5'd11, 64'hB0B0); s.out_ready = 1'b0; applyStimulus(s);
    #2 checkOutput("bp_in_ready", in_ready_o, 0);
    for (int i = 0; i < 3; i++) applyStimulus(idle(1'b1));

    // flush while full, with a colliding upstream request
    s = exu_op(64'h8000_0300, 5'd12, 64'hC1); s.out_ready = 1'b0; applyStimulus(s);
    s = exu_op(64'h8000_0304, 5'd13, 64'hC2); s.out_ready = 1'b0; applyStimulus(s);
    s = exu_op(64'h8000_0308, 5'd14, 64'hC3); s.out_ready = 1'b0; s.flush = 1'b1; applyStimulus(s);
    #2;
    checkOutput("flush_valid", out_valid_o, 0);
    checkOutput("flush_ready", in_ready_o, 1);
    applyStimulus(idle(1'b1)); applyStimulus(idle(1'b1));

    // load to x0 keeps data but not the write enable
    s = idle(1'b1); s.in_valid = 1'b1; s.pc = 64'h8000_0400; s.inst = 32'h00003003;
    s.lsu_we = 1'b1; s.lsu_addr = 5'd0; s.lsu_data = 64'h99;
    applyStimulus(s);
    #2;
    checkOutput("x0_we", reg_we_o, 0);
    checkOutput("x0_wdata", reg_wdata_o, 64'h99);
    applyStimulus(idle(1'b1));

    // ebreak with a CSR snapshot
    s = idle(1'b1); s.in_valid = 1'b1; s.pc = 64'h8000_0500; s.inst = 32'h00100073;
    s.snap[127:64] = 64'h8000_0004; s.snap[63:0] = 64'h1234;
    applyStimulus(s);
    #2;
`ifdef YSYX_22050019_DIFFTEST_EN
    exp_eb = 1'b1; exp_w1 = 64'h8000_0004;
`else
    exp_eb = 1'b0; exp_w1 = 64'h0;
`endif
    checkOutput("ebreak_pulse", ebreak_o, exp_eb);
    checkOutput("snap_word1", csr_snap_o[127:64], exp_w1);
    applyStimulus(idle(1'b1));

    // reset mid-stream, then nine commits wrap the 3-bit counter to 1
    applyStimulus(exu_op(64'h8000_0600, 5'd3, 64'h3)); s = idle(1'b0); s.rst = 1'b1;
    applyStimulus(s); applyStimulus(s);
    for (int i = 0; i < 9; i++) applyStimulus(exu_op(64'h8000_0700 + 64'(4 * i), 5'(i + 1), 64'(i)));
    applyStimulus(idle(1'b1));
    #2 checkOutput("wrap_retire", retire_cnt_o, 1);

    // drain with a bounded cycle budget
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) applyStimulus(idle(1'b1));
    checkOutput("drain_empty", sb_q.size() == 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
